// File: rtl/mpu_load_stream_if.sv
// Load-stream bus: command, element beats, status and register-file write port.
// The slave view belongs to the loader; the master view belongs to its environment.
interface mpu_load_stream_if #(
    parameter int FP       = 32,
    parameter int M        = 4,
    parameter int N        = 4,
    parameter int NUM_MREG = 4
);
    localparam int MBITS = $clog2(M + 1);
    localparam int NBITS = $clog2(N + 1);
    localparam int ABITS = (NUM_MREG > 1) ? $clog2(NUM_MREG) : 1;

    logic             cmd_valid_in;
    logic             cmd_ready_out;
    logic [MBITS-1:0] mem_m_load_size_in;
    logic [NBITS-1:0] mem_n_load_size_in;
    logic [ABITS-1:0] mem_load_addr_in;
    logic             mem_transpose_in;

    logic             mem_elem_valid_in;
    logic             mem_elem_ready_out;
    logic [FP-1:0]    mem_load_element_in;
    logic             abort_in;

    logic             mem_load_error_out;
    logic [1:0]       mem_load_err_code_out;
    logic             mem_load_done_out;

    logic             reg_load_en_out;
    logic             reg_load_ready_in;
    logic [ABITS-1:0] reg_load_addr_out;
    logic [FP-1:0]    reg_load_element_out;
    logic [MBITS-1:0] reg_i_load_loc_out;
    logic [NBITS-1:0] reg_j_load_loc_out;
    logic [MBITS-1:0] reg_m_load_size_out;
    logic [NBITS-1:0] reg_n_load_size_out;

    modport slave (
        input  cmd_valid_in,
        output cmd_ready_out,
        input  mem_m_load_size_in,
        input  mem_n_load_size_in,
        input  mem_load_addr_in,
        input  mem_transpose_in,
        input  mem_elem_valid_in,
        output mem_elem_ready_out,
        input  mem_load_element_in,
        input  abort_in,
        output mem_load_error_out,
        output mem_load_err_code_out,
        output mem_load_done_out,
        output reg_load_en_out,
        input  reg_load_ready_in,
        output reg_load_addr_out,
        output reg_load_element_out,
        output reg_i_load_loc_out,
        output reg_j_load_loc_out,
        output reg_m_load_size_out,
        output reg_n_load_size_out
    );

    modport master (
        output cmd_valid_in,
        input  cmd_ready_out,
        output mem_m_load_size_in,
        output mem_n_load_size_in,
        output mem_load_addr_in,
        output mem_transpose_in,
        output mem_elem_valid_in,
        input  mem_elem_ready_out,
        output mem_load_element_in,
        output abort_in,
        input  mem_load_error_out,
        input  mem_load_err_code_out,
        input  mem_load_done_out,
        input  reg_load_en_out,
        output reg_load_ready_in,
        input  reg_load_addr_out,
        input  reg_load_element_out,
        input  reg_i_load_loc_out,
        input  reg_j_load_loc_out,
        input  reg_m_load_size_out,
        input  reg_n_load_size_out
    );
endinterface

// File: rtl/mpu_load_stream.sv
// Streaming matrix loader: one command, then one element per beat into the
// matrix register file through a single back-pressured output stage.
module mpu_load_stream #(
    parameter int FP       = 32,
    parameter int M        = 4,
    parameter int N        = 4,
    parameter int NUM_MREG = 4
) (
    input logic              clk,
    input logic              rst,
    mpu_load_stream_if.slave bus
);
    localparam int MBITS = $clog2(M + 1);
    localparam int NBITS = $clog2(N + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [MBITS-1:0] M_ONE = MBITS'(1);
    localparam logic [NBITS-1:0] N_ONE = NBITS'(1);

    logic [1:0]       state;
    logic [MBITS-1:0] m_size;
    logic [NBITS-1:0] n_size;
    logic             trans;
    logic [MBITS-1:0] row;
    logic [NBITS-1:0] col;

    logic dims_bad;
    logic addr_bad;
    logic cmd_take;
    logic beat;
    logic out_acc;
    logic abort;
    logic col_last;
    logic row_last;

    // Command validation; sizes are widened so the limit checks never wrap.
    always_comb begin
        dims_bad = (bus.mem_m_load_size_in == '0)
                || (bus.mem_n_load_size_in == '0)
                || (32'(bus.mem_m_load_size_in) > M)
                || (32'(bus.mem_n_load_size_in) > N)
                || (bus.mem_transpose_in
                    && ((32'(bus.mem_n_load_size_in) > M)
                     || (32'(bus.mem_m_load_size_in) > N)));
        addr_bad = 32'(bus.mem_load_addr_in) >= NUM_MREG;
        cmd_take = (state == IDLE) && bus.cmd_valid_in
                && !dims_bad && !addr_bad;
    end

    // Handshakes: element ready whenever the output stage is empty or draining.
    always_comb begin
        bus.cmd_ready_out      = (state == IDLE);
        bus.mem_elem_ready_out = (state == LOAD)
                              && (!bus.reg_load_en_out || bus.reg_load_ready_in);
        beat     = bus.mem_elem_valid_in && bus.mem_elem_ready_out;
        out_acc  = bus.reg_load_en_out && bus.reg_load_ready_in;
        abort    = bus.abort_in && (state != IDLE);
        col_last = (col == n_size - N_ONE);
        row_last = (row == m_size - M_ONE);
    end

    // Control: state, source-order counters and the sticky error status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                     <= IDLE;
            m_size                    <= '0;
            n_size                    <= '0;
            trans                     <= 1'b0;
            row                       <= '0;
            col                       <= '0;
            bus.mem_load_error_out    <= 1'b0;
            bus.mem_load_err_code_out <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid_in) begin
                        if (dims_bad) begin
                            bus.mem_load_error_out    <= 1'b1;
                            bus.mem_load_err_code_out <= 2'd1;
                        end else if (addr_bad) begin
                            bus.mem_load_error_out    <= 1'b1;
                            bus.mem_load_err_code_out <= 2'd2;
                        end else begin
                            m_size                    <= bus.mem_m_load_size_in;
                            n_size                    <= bus.mem_n_load_size_in;
                            trans                     <= bus.mem_transpose_in;
                            row                       <= '0;
                            col                       <= '0;
                            bus.mem_load_error_out    <= 1'b0;
                            bus.mem_load_err_code_out <= 2'd0;
                            state                     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        bus.mem_load_error_out    <= 1'b1;
                        bus.mem_load_err_code_out <= 2'd3;
                        state                     <= IDLE;
                    end else if (beat) begin
                        if (col_last) begin
                            col <= '0;
                            row <= row + M_ONE;
                            if (row_last) begin
                                state <= DRAIN;
                            end
                        end else begin
                            col <= col + N_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        bus.mem_load_error_out    <= 1'b1;
                        bus.mem_load_err_code_out <= 2'd3;
                        state                     <= IDLE;
                    end else if (out_acc) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output stage: one held register-file write, replaced at full rate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mem_load_done_out    <= 1'b0;
            bus.reg_load_en_out      <= 1'b0;
            bus.reg_load_addr_out    <= '0;
            bus.reg_load_element_out <= '0;
            bus.reg_i_load_loc_out   <= '0;
            bus.reg_j_load_loc_out   <= '0;
            bus.reg_m_load_size_out  <= '0;
            bus.reg_n_load_size_out  <= '0;
        end else begin
            bus.mem_load_done_out <= 1'b0;
            if (cmd_take) begin
                bus.reg_load_addr_out <= bus.mem_load_addr_in;
                if (bus.mem_transpose_in) begin
                    bus.reg_m_load_size_out <= MBITS'(bus.mem_n_load_size_in);
                    bus.reg_n_load_size_out <= NBITS'(bus.mem_m_load_size_in);
                end else begin
                    bus.reg_m_load_size_out <= bus.mem_m_load_size_in;
                    bus.reg_n_load_size_out <= bus.mem_n_load_size_in;
                end
            end
            if (abort) begin
                bus.reg_load_en_out <= 1'b0;
            end else if (beat) begin
                bus.reg_load_en_out      <= 1'b1;
                bus.reg_load_element_out <= bus.mem_load_element_in;
                if (trans) begin
                    bus.reg_i_load_loc_out <= MBITS'(col);
                    bus.reg_j_load_loc_out <= NBITS'(row);
                end else begin
                    bus.reg_i_load_loc_out <= row;
                    bus.reg_j_load_loc_out <= col;
                end
            end else if (out_acc) begin
                bus.reg_load_en_out   <= 1'b0;
                bus.mem_load_done_out <= (state == DRAIN);
            end
        end
    end
endmodule

// File: tb/tb_mpu_load_stream.sv
// Bench for mpu_load_stream: command table, scoreboarded loads,
// abort and asynchronous reset sequences.
`timescale 1ns/1ps
module tb_mpu_load_stream;
    localparam int FP = 32;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int NR = 3;
    localparam int MB = 3;
    localparam int NB = 3;
    localparam int AB = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mpu_load_stream_if #(.FP(FP), .M(M), .N(N), .NUM_MREG(NR)) bus ();

    mpu_load_stream #(.FP(FP), .M(M), .N(N), .NUM_MREG(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [MB-1:0] m;
        logic [NB-1:0] n;
        logic [AB-1:0] a;
        logic          t;
        logic          err;
        logic [1:0]    code;
        logic          take;
    } cvec_t;

    typedef struct {
        int          i;
        int          j;
        logic [31:0] d;
    } wr_t;

    int tests = 0;
    int fails = 0;
    cvec_t tbl [9];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.cmd_valid_in        = 1'b0;
        bus.mem_m_load_size_in  = '0;
        bus.mem_n_load_size_in  = '0;
        bus.mem_load_addr_in    = '0;
        bus.mem_transpose_in    = 1'b0;
        bus.mem_elem_valid_in   = 1'b0;
        bus.mem_load_element_in = '0;
        bus.abort_in            = 1'b0;
        bus.reg_load_ready_in   = 1'b0;
    endtask

    task automatic chk_idle_reset(string tag);
        chk({tag, "_cmdrdy"}, 64'(bus.cmd_ready_out), 64'd1);
        chk({tag, "_elemrdy"}, 64'(bus.mem_elem_ready_out), 64'd0);
        chk({tag, "_en"}, 64'(bus.reg_load_en_out), 64'd0);
        chk({tag, "_err"}, 64'(bus.mem_load_error_out), 64'd0);
        chk({tag, "_code"}, 64'(bus.mem_load_err_code_out), 64'd0);
        chk({tag, "_done"}, 64'(bus.mem_load_done_out), 64'd0);
        chk({tag, "_data"}, 64'(bus.reg_load_element_out), 64'd0);
        chk({tag, "_i"}, 64'(bus.reg_i_load_loc_out), 64'd0);
        chk({tag, "_msz"}, 64'(bus.reg_m_load_size_out), 64'd0);
        chk({tag, "_addr"}, 64'(bus.reg_load_addr_out), 64'd0);
    endtask

    // Reference: row-major source stream, destination (c,r) when transposed;
    // at most one write pending; done the cycle after the final write.
    task automatic do_load(input int m, input int n, input int a, input bit t,
                           input bit rnd, input int abort_after);
        logic [31:0] src[$];
        wr_t         exp[$];
        int          total;
        int          acc;
        int          wr;
        int          cyc_n;
        bit          pend;
        bit          done_exp;
        bit          rdy_exp;
        bit          bt;
        bit          wrt;
        bit          aborted;
        total    = m * n;
        acc      = 0;
        wr       = 0;
        cyc_n    = 0;
        pend     = 1'b0;
        done_exp = 1'b0;
        aborted  = 1'b0;
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                wr_t e;
                e.d = $urandom;
                e.i = t ? c : r;
                e.j = t ? r : c;
                src.push_back(e.d);
                exp.push_back(e);
            end
        end
        clr();
        bus.cmd_valid_in       = 1'b1;
        bus.mem_m_load_size_in = MB'(m);
        bus.mem_n_load_size_in = NB'(n);
        bus.mem_load_addr_in   = AB'(a);
        bus.mem_transpose_in   = t;
        cyc();
        bus.cmd_valid_in = 1'b0;
        chk("ld_err", 64'(bus.mem_load_error_out), 64'd0);
        chk("ld_code", 64'(bus.mem_load_err_code_out), 64'd0);
        chk("ld_cmdrdy", 64'(bus.cmd_ready_out), 64'd0);
        chk("ld_msz", 64'(bus.reg_m_load_size_out), 64'(t ? n : m));
        chk("ld_nsz", 64'(bus.reg_n_load_size_out), 64'(t ? m : n));
        chk("ld_addr", 64'(bus.reg_load_addr_out), 64'(a));
        while (wr < total && cyc_n < 2000 && !aborted) begin
            bus.reg_load_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.mem_elem_valid_in = (acc < total)
                                 && (!rnd || ($urandom_range(0, 2) != 0));
            bus.mem_load_element_in = (acc < total) ? src[acc] : $urandom;
            if (acc == abort_after) begin
                bus.abort_in          = 1'b1;
                bus.mem_elem_valid_in = 1'b0;
                bus.reg_load_ready_in = 1'b0;
            end
            #2;
            rdy_exp = (acc < total) && (!pend || bus.reg_load_ready_in);
            chk("en", 64'(bus.reg_load_en_out), 64'(pend));
            chk("done", 64'(bus.mem_load_done_out), 64'(done_exp));
            if (!bus.abort_in) begin
                chk("elem_rdy", 64'(bus.mem_elem_ready_out), 64'(rdy_exp));
            end
            if (pend) begin
                chk("data", 64'(bus.reg_load_element_out), 64'(exp[wr].d));
                chk("loc_i", 64'(bus.reg_i_load_loc_out), 64'(exp[wr].i));
                chk("loc_j", 64'(bus.reg_j_load_loc_out), 64'(exp[wr].j));
            end
            if (bus.abort_in) begin
                aborted = 1'b1;
                cyc();
                bus.abort_in = 1'b0;
                chk("ab_en", 64'(bus.reg_load_en_out), 64'd0);
                chk("ab_err", 64'(bus.mem_load_error_out), 64'd1);
                chk("ab_code", 64'(bus.mem_load_err_code_out), 64'd3);
                chk("ab_cmdrdy", 64'(bus.cmd_ready_out), 64'd1);
                for (int k = 0; k < 3; k++) begin
                    chk("ab_nodone", 64'(bus.mem_load_done_out), 64'd0);
                    cyc();
                end
            end else begin
                wrt = pend && bus.reg_load_ready_in;
                bt  = bus.mem_elem_valid_in && rdy_exp;
                if (wrt) wr++;
                if (bt) acc++;
                pend     = bt ? 1'b1 : (wrt ? 1'b0 : pend);
                done_exp = wrt && (wr == total);
                cyc();
                cyc_n++;
            end
        end
        if (!aborted) begin
            if (wr < total) begin
                chk("timeout", 64'(wr), 64'(total));
            end
            clr();
            #2;
            chk("done_end", 64'(bus.mem_load_done_out), 64'(done_exp));
            chk("end_cmdrdy", 64'(bus.cmd_ready_out), 64'd1);
            chk("end_en", 64'(bus.reg_load_en_out), 64'd0);
            cyc();
            chk("done_pulse", 64'(bus.mem_load_done_out), 64'd0);
        end
        clr();
    endtask

    initial begin
        tbl[0] = '{m:3'd0, n:3'd2, a:2'd0, t:1'b0, err:1'b1, code:2'd1, take:1'b0};
        tbl[1] = '{m:3'd2, n:3'd5, a:2'd0, t:1'b0, err:1'b1, code:2'd1, take:1'b0};
        tbl[2] = '{m:3'd2, n:3'd2, a:2'd3, t:1'b0, err:1'b1, code:2'd2, take:1'b0};
        tbl[3] = '{m:3'd5, n:3'd1, a:2'd1, t:1'b0, err:1'b1, code:2'd1, take:1'b0};
        tbl[4] = '{m:3'd4, n:3'd4, a:2'd2, t:1'b0, err:1'b0, code:2'd0, take:1'b1};
        tbl[5] = '{m:3'd7, n:3'd0, a:2'd3, t:1'b0, err:1'b1, code:2'd1, take:1'b0};
        tbl[6] = '{m:3'd3, n:3'd0, a:2'd0, t:1'b1, err:1'b1, code:2'd1, take:1'b0};
        tbl[7] = '{m:3'd1, n:3'd4, a:2'd0, t:1'b1, err:1'b0, code:2'd0, take:1'b1};
        tbl[8] = '{m:3'd2, n:3'd3, a:2'd3, t:1'b1, err:1'b1, code:2'd2, take:1'b0};

        clr();
        rst = 1'b0;
        #3;
        chk_idle_reset("rst");
        #4;
        rst = 1'b1;
        cyc();

        for (int k = 0; k < 9; k++) begin
            bus.cmd_valid_in       = 1'b1;
            bus.mem_m_load_size_in = tbl[k].m;
            bus.mem_n_load_size_in = tbl[k].n;
            bus.mem_load_addr_in   = tbl[k].a;
            bus.mem_transpose_in   = tbl[k].t;
            #2;
            chk("tbl_cmdrdy_pre", 64'(bus.cmd_ready_out), 64'd1);
            cyc();
            clr();
            #2;
            chk("tbl_err", 64'(bus.mem_load_error_out), 64'(tbl[k].err));
            chk("tbl_code", 64'(bus.mem_load_err_code_out), 64'(tbl[k].code));
            chk("tbl_cmdrdy", 64'(bus.cmd_ready_out), 64'(!tbl[k].take));
            chk("tbl_en", 64'(bus.reg_load_en_out), 64'd0);
            if (tbl[k].take) begin
                cyc();
                bus.abort_in = 1'b1;
                cyc();
                bus.abort_in = 1'b0;
                #2;
                chk("tbl_ab_code", 64'(bus.mem_load_err_code_out), 64'd3);
                chk("tbl_ab_cmdrdy", 64'(bus.cmd_ready_out), 64'd1);
            end
            cyc();
        end

        do_load(2, 3, 1, 1'b0, 1'b0, -1);
        do_load(2, 3, 1, 1'b1, 1'b0, -1);
        do_load(1, 1, 0, 1'b0, 1'b0, -1);
        for (int k = 0; k < 8; k++) begin
            do_load(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    1'b1, -1);
        end
        do_load(4, 4, 0, 1'b0, 1'b0, 3);
        do_load(4, 4, 2, 1'b1, 1'b1, -1);
        do_load(3, 2, 1, 1'b0, 1'b1, 4);
        do_load(3, 2, 2, 1'b0, 1'b1, -1);

        clr();
        bus.cmd_valid_in       = 1'b1;
        bus.mem_m_load_size_in = 3'd1;
        bus.mem_n_load_size_in = 3'd1;
        bus.mem_load_addr_in   = 2'd2;
        cyc();
        bus.cmd_valid_in        = 1'b0;
        bus.mem_elem_valid_in   = 1'b1;
        bus.mem_load_element_in = 32'hDEADBEEF;
        bus.reg_load_ready_in   = 1'b0;
        cyc();
        bus.mem_elem_valid_in = 1'b0;
        #2;
        chk("dr_en", 64'(bus.reg_load_en_out), 64'd1);
        chk("dr_data", 64'(bus.reg_load_element_out), 64'hDEADBEEF);
        chk("dr_elemrdy", 64'(bus.mem_elem_ready_out), 64'd0);
        chk("dr_cmdrdy", 64'(bus.cmd_ready_out), 64'd0);
        rst = 1'b0;
        #1;
        chk_idle_reset("async");
        #3;
        rst = 1'b1;
        cyc();
        chk("post_rst_cmdrdy", 64'(bus.cmd_ready_out), 64'd1);
        do_load(1, 4, 0, 1'b1, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
